param_memory_ctrl: RTL

//  Parametrised successor of the 8x8 memory module: DEPTH words of DATA_W bits, single port,
//  i_select/i_op access (op=1 write, op=0 read) with registered read data and an o_valid strobe.

---
 rtl/param_memory_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/param_memory_ctrl.sv
// Parametrised single-port word memory with a clear-sweep FSM, ready gating and
// dropped-request / address-error strobes. All outputs are registered.
module param_memory_ctrl #(
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 8,
  localparam int               ADDR_W   = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_select,
  input  logic              i_op,
  input  logic [ADDR_W-1:0] i_adr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_clear,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_ready,
  output logic              o_drop,
  output logic              o_err
);

  typedef enum logic {CLEAR, IDLE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              sweep_we;
  logic              accept;
  logic              in_range;
  logic              wr_en;
  logic              rd_en;
  logic              ready_next;
  logic [DATA_W-1:0] rd_word;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // A clear request in IDLE always restarts the sweep; during CLEAR it is ignored.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR: if (cnt == LAST_ADR) state_next = IDLE;
      IDLE:  if (i_clear)         state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  // o_ready lags IDLE entry by one cycle, so requests are only taken once it is visible.
  always_comb begin
    sweep_we   = (state == CLEAR);
    in_range   = ({1'b0, i_adr} < DEPTH_EXT);
    accept     = i_select && o_ready && (state == IDLE) && !i_clear;
    wr_en      = accept && i_op && in_range;
    rd_en      = accept && !i_op;
    ready_next = (state == IDLE) && !i_clear;
    rd_word    = in_range ? mem[i_adr] : INIT_VAL;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (state == CLEAR) begin
      cnt <= (cnt == LAST_ADR) ? '0 : cnt + ADDR_W'(1);
    end else if (i_clear) begin
      cnt <= '0;
    end
  end

  // Storage has no reset; the sweep after every reset initialises it.
  always_ff @(posedge i_clk) begin
    if (sweep_we) begin
      mem[cnt] <= INIT_VAL;
    end else if (wr_en) begin
      mem[i_adr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data  <= '0;
      o_valid <= 1'b0;
      o_ready <= 1'b0;
      o_drop  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_valid <= rd_en;
      o_ready <= ready_next;
      o_drop  <= i_select && !accept;
      o_err   <= rd_en && !in_range;
      if (rd_en) begin
        o_data <= rd_word;
      end
    end
  end

endmodule
